// File: rtl/fetch_queue.sv
// Instruction fetch byte queue: issues aligned 8-byte fetches, packs responses into a byte FIFO
// and retires variable-length instructions. Optional perf counters under FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int FQ_CAP   = 24,
  parameter int FQ_OUTST = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect,
  input  logic [63:0]  redirect_pc,
  output logic         imem_req_valid,
  output logic [63:0]  imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [63:0]  imem_rsp_data,
  output logic [119:0] fq_bytes,
  output logic [4:0]   fq_count,
  output logic [63:0]  fq_pc,
  input  logic         dec_consume,
  input  logic [3:0]   dec_len,
  output logic         fq_underrun
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]  perf_starve,
  output logic [31:0]  perf_full,
  output logic [31:0]  perf_drop
`endif
);

  localparam int CW = $clog2(FQ_CAP + 1);
  localparam int OW = $clog2(FQ_OUTST + 1);

  logic [7:0]    mem_q [FQ_CAP];
  logic [7:0]    mem_d [FQ_CAP];
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   pc_q, fetch_addr_q;
  logic [OW-1:0] outst_q, drop_q;
  logic          fetch_en_q, underrun_q, first_q;
  logic [2:0]    skip_q;

  logic consume_ok, rsp_take, rsp_drop, rsp_app;
  logic slots_ok, cap_ok, req_base, req_fire;
  int   shamt, skip, app_n, rem;

  // Requests reserve 8 bytes each so in-flight data always fits when it returns.
  always_comb begin
    slots_ok       = int'(outst_q) < FQ_OUTST;
    cap_ok         = int'(count_q) + 8 * int'(outst_q) + 8 <= FQ_CAP;
    req_base       = !rst && fetch_en_q && !redirect && slots_ok;
    imem_req_valid = req_base && cap_ok;
    imem_req_addr  = fetch_addr_q;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    consume_ok = dec_consume && (dec_len != 4'd0) && (int'(dec_len) <= int'(count_q));
    shamt      = consume_ok ? int'(dec_len) : 0;
    rsp_take   = imem_rsp_valid && fetch_en_q && (outst_q != '0);
    rsp_drop   = rsp_take && (drop_q != '0);
    rsp_app    = rsp_take && (drop_q == '0);
    skip       = first_q ? int'(skip_q) : 0;
    app_n      = rsp_app ? 8 - skip : 0;
    rem        = int'(count_q) - shamt;
    for (int i = 0; i < FQ_CAP; i++) begin
      mem_d[i] = mem_q[i];
      if (i < rem)
        mem_d[i] = mem_q[i + shamt];
      else if (i - rem < app_n)
        mem_d[i] = imem_rsp_data[8 * (i - rem + skip) +: 8];
    end
    count_d = CW'(rem + app_n);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      pc_q         <= '0;
      fetch_addr_q <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      fetch_en_q   <= 1'b0;
      underrun_q   <= 1'b0;
      first_q      <= 1'b0;
      skip_q       <= '0;
    end else if (redirect) begin
      count_q      <= '0;
      pc_q         <= redirect_pc;
      fetch_addr_q <= {redirect_pc[63:3], 3'b000};
      outst_q      <= outst_q - OW'(rsp_take);
      drop_q       <= outst_q - OW'(rsp_take);
      fetch_en_q   <= 1'b1;
      underrun_q   <= 1'b0;
      first_q      <= 1'b1;
      skip_q       <= redirect_pc[2:0];
    end else begin
      count_q <= count_d;
      pc_q    <= pc_q + 64'(shamt);
      outst_q <= outst_q + OW'(req_fire) - OW'(rsp_take);
      if (req_fire) fetch_addr_q <= fetch_addr_q + 64'd8;
      if (rsp_drop) drop_q <= drop_q - OW'(1);
      if (rsp_app)  first_q <= 1'b0;
      if (dec_consume && !consume_ok) underrun_q <= 1'b1;
    end
  end

  // NOTE: the byte array carries no reset; count_q alone decides which bytes are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FQ_CAP; i++) mem_q[i] <= mem_d[i];
  end

  always_comb begin
    for (int k = 0; k < 15; k++) fq_bytes[8*k +: 8] = mem_q[k];
    fq_count    = 5'(count_q);
    fq_pc       = pc_q;
    fq_underrun = underrun_q;
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic starve_ev, full_ev, drop_ev;

  always_comb begin
    starve_ev = fetch_en_q && (count_q == '0);
    full_ev   = req_base && !cap_ok;
    drop_ev   = redirect ? rsp_take : rsp_drop;
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_starve <= '0;
      perf_full   <= '0;
      perf_drop   <= '0;
    end else begin
      if (starve_ev && !(&perf_starve)) perf_starve <= perf_starve + 32'd1;
      if (full_ev   && !(&perf_full))   perf_full   <= perf_full + 32'd1;
      if (drop_ev   && !(&perf_drop))   perf_drop   <= perf_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, checked against a byte-queue
// model where requests carry an epoch and stale-epoch responses are simply not appended.
module tb_fetch_queue;

  logic         clk = 1'b0;
  logic         rst, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic         dec_consume, fq_underrun;
  logic [63:0]  redirect_pc, imem_req_addr, imem_rsp_data, fq_pc;
  logic [119:0] fq_bytes;
  logic [4:0]   fq_count;
  logic [3:0]   dec_len;

  fetch_queue dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .fq_bytes(fq_bytes), .fq_count(fq_count),
    .fq_pc(fq_pc), .dec_consume(dec_consume), .dec_len(dec_len),
    .fq_underrun(fq_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
  } req_t;

  req_t        inflight[$];
  logic [7:0]  mq[$];
  logic [63:0] m_pc, m_fetch, m_base;
  int          m_epoch;
  bit          m_en, m_und;
  int          n_checks, n_errors;
  bit          req_seen;
  logic [63:0] req_addr_seen;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[23:16] ^ a[39:32];
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = mem_byte(a + 64'(j));
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [119:0] mask, exp;
    mask = '0;
    exp  = '0;
    for (int k = 0; k < 15; k++)
      if (k < mq.size()) begin
        mask[8*k +: 8] = 8'hff;
        exp[8*k +: 8]  = mq[k];
      end
    check("fq_count", 128'(fq_count), 128'(mq.size()));
    check("fq_pc", 128'(fq_pc), 128'(m_pc));
    check("fq_underrun", 128'(fq_underrun), 128'(m_und));
    check("fq_bytes", 128'(fq_bytes & mask), 128'(exp));
  endtask

  // One clock cycle: drive inputs, check the request, advance the model, check the new state.
  task automatic step(input bit r, input bit rd, input logic [63:0] rpc, input bit rdy,
                      input bit rv, input bit cons, input logic [3:0] len);
    bit   exp_req, rv_eff, hit;
    req_t e;
    rv_eff = rv && (inflight.size() > 0 || !m_en);
    hit    = rv_eff && inflight.size() > 0;
    rst            = r;
    redirect       = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rv_eff;
    imem_rsp_data  = hit ? mem_word(inflight[0].addr) : {$urandom, $urandom};
    dec_consume    = cons;
    dec_len        = len;
    exp_req = !r && m_en && !rd && inflight.size() < 2 &&
              (mq.size() + 8 * inflight.size() + 8 <= 24);
    #1;
    req_seen      = imem_req_valid;
    req_addr_seen = imem_req_addr;
    check("req_valid", 128'(imem_req_valid), 128'(exp_req));
    if (exp_req) check("req_addr", 128'(imem_req_addr), 128'(m_fetch));

    if (r) begin
      mq.delete();
      inflight.delete();
      m_pc = '0; m_fetch = '0; m_en = 0; m_und = 0;
    end else if (rd) begin
      if (hit) void'(inflight.pop_front());
      mq.delete();
      m_pc = rpc; m_base = rpc; m_fetch = {rpc[63:3], 3'b000};
      m_und = 0; m_en = 1; m_epoch++;
    end else begin
      if (hit) e = inflight.pop_front();
      if (cons) begin
        if (len != 0 && int'(len) <= mq.size()) begin
          repeat (int'(len)) void'(mq.pop_front());
          m_pc += 64'(len);
        end else m_und = 1;
      end
      if (hit && e.epoch == m_epoch)
        for (int j = 0; j < 8; j++)
          if (e.addr + 64'(j) >= m_base) mq.push_back(mem_byte(e.addr + 64'(j)));
      if (exp_req && rdy) begin
        inflight.push_back('{m_fetch, m_epoch});
        m_fetch += 64'd8;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    logic [7:0]  old4;
    logic [63:0] old_pc, addrs[$];
    n_checks = 0; n_errors = 0; m_epoch = 0; m_base = '0;
    m_pc = '0; m_fetch = '0; m_en = 0; m_und = 0;

    // Reset state and idle before the first redirect.
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_count", 128'(fq_count), 128'(0));
    check("rst_pc", 128'(fq_pc), 128'(0));
    step(0, 0, 0, 1, 0, 0, 0);
    check("idle_no_req", 128'(req_seen), 128'(0));

    // Unaligned redirect: first response drops the low three bytes.
    step(0, 1, 64'h1003, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("r35_req", 128'(req_seen), 128'(1));
    check("r35_addr", 128'(req_addr_seen), 128'(64'h1000));
    step(0, 0, 0, 0, 1, 0, 0);
    check("r35_count", 128'(fq_count), 128'(5));
    check("r35_byte0", 128'(fq_bytes[7:0]), 128'(8'h03));
    check("r35_pc", 128'(fq_pc), 128'(64'h1003));

    // Consume and append in the same cycle.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4'd3);
    step(0, 0, 0, 1, 0, 0, 0);
    check("r37_pre_count", 128'(fq_count), 128'(10));
    old4   = fq_bytes[39:32];
    old_pc = fq_pc;
    step(0, 0, 0, 0, 1, 1, 4'd4);
    check("r37_count", 128'(fq_count), 128'(14));
    check("r37_pc", 128'(fq_pc), 128'(old_pc + 64'd4));
    check("r37_byte0", 128'(fq_bytes[7:0]), 128'(old4));

    // Illegal consume is ignored and sets the sticky flag.
    step(0, 0, 0, 0, 0, 1, 4'd11);
    check("r39_pre_count", 128'(fq_count), 128'(3));
    step(0, 0, 0, 0, 0, 1, 4'd5);
    check("r39_count", 128'(fq_count), 128'(3));
    check("r39_underrun", 128'(fq_underrun), 128'(1));
    step(0, 0, 0, 0, 0, 1, 4'd0);
    check("r39_len0_count", 128'(fq_count), 128'(3));

    // Redirect with two requests in flight: both responses dropped.
    step(0, 1, 64'h4000, 0, 0, 0, 0);
    check("r39_cleared", 128'(fq_underrun), 128'(0));
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("r38_two_out", 128'(req_seen), 128'(1));
    step(0, 1, 64'h3000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("r38_drop1", 128'(fq_count), 128'(0));
    step(0, 0, 0, 0, 1, 0, 0);
    check("r38_drop2", 128'(fq_count), 128'(0));
    step(0, 0, 0, 1, 0, 0, 0);
    check("r38_addr", 128'(req_addr_seen), 128'(64'h3000));
    step(0, 0, 0, 0, 1, 0, 0);
    check("r38_count", 128'(fq_count), 128'(8));
    check("r38_pc", 128'(fq_pc), 128'(64'h3000));

    // Always-ready memory, no consume: fill to capacity with three requests.
    step(0, 1, 64'h2000, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 1, 0, 0);
      if (req_seen) addrs.push_back(req_addr_seen);
    end
    check("r36_nreq", 128'(addrs.size()), 128'(3));
    for (int i = 0; i < addrs.size() && i < 3; i++)
      check("r36_addr", 128'(addrs[i]), 128'(64'h2000 + 64'(8 * i)));
    check("r36_count", 128'(fq_count), 128'(24));
    check("r36_held", 128'(req_seen), 128'(0));

    // Reset mid-stream with a response arriving in the reset cycle.
    step(0, 1, 64'h5005, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    check("r40_count", 128'(fq_count), 128'(0));
    check("r40_pc", 128'(fq_pc), 128'(0));
    step(0, 0, 0, 1, 1, 0, 0);
    check("r40_no_req", 128'(req_seen), 128'(0));
    check("r40_no_append", 128'(fq_count), 128'(0));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          r, rd, rdy, rv, cons;
      logic [3:0]  len;
      logic [63:0] rpc;
      r    = ($urandom_range(0, 499) == 0);
      rd   = (i == 0) || ($urandom_range(0, 29) == 0);
      rpc  = {32'h0, $urandom};
      rdy  = 1'($urandom_range(0, 1));
      rv   = ($urandom_range(0, 2) != 0);
      cons = 1'($urandom_range(0, 1));
      len  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step(r, rd, rpc, rdy, rv, cons, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
